// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: default widths and writeback-select encodings.
// Also imported by the decode/control block.
package wb_regfile_pkg;

  localparam int DBITS_DEFAULT = 32;
  localparam int REGNO_DEFAULT = 4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_ILL = 2'd3;

  function automatic logic is_legal_sel(input logic [1:0] sel);
    return sel != WB_ILL;
  endfunction

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Architectural register file: two asynchronous read ports, one synchronous write
// port and a synchronous clear of every entry.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int REGNO = REGNO_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [REGNO-1:0] wr_idx,
  input  logic [DBITS-1:0] wr_data,
  input  logic [REGNO-1:0] rd1_idx,
  input  logic [REGNO-1:0] rd2_idx,
  output logic [DBITS-1:0] rd1_data,
  output logic [DBITS-1:0] rd2_data
);

  localparam int DEPTH = 1 << REGNO;

  logic [DBITS-1:0] reg_arr [DEPTH];

  // Each entry is its own flop so clear and write stay a simple per-entry mux.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DBITS-1:0] reg_q;
      logic [DBITS-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (reset) begin
          reg_d = '0;
        end else if (wr_en && (wr_idx == REGNO'(gi))) begin
          reg_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        reg_q <= reg_d;
      end

      assign reg_arr[gi] = reg_q;
    end
  endgenerate

  assign rd1_data = reg_arr[rd1_idx];
  assign rd2_data = reg_arr[rd2_idx];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// bypasses it to the decode read ports, and tracks retirements and illegal selects.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int REGNO = REGNO_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_W,
  input  logic             noop_W,
  input  logic             regWrtEn_W,
  input  logic [1:0]       regFileMux_W,
  input  logic [REGNO-1:0] destIndex_W,
  input  logic [DBITS-1:0] ALUresult_W,
  input  logic [DBITS-1:0] MEMresult_W,
  input  logic [DBITS-1:0] incPC_W,
  input  logic [REGNO-1:0] src1Index_D,
  input  logic [REGNO-1:0] src2Index_D,
  output logic [DBITS-1:0] src1Data_D,
  output logic [DBITS-1:0] src2Data_D,
  output logic [DBITS-1:0] wbData_W,
  output logic             commit_W,
  output logic [31:0]      retire_count,
  output logic             wb_err
);

  logic [DBITS-1:0] rf_rd1;
  logic [DBITS-1:0] rf_rd2;
  logic             retire;
  logic             ill_write;
  logic [31:0]      retire_count_q;
  logic [31:0]      retire_count_d;
  logic             wb_err_q;
  logic             wb_err_d;

  always_comb begin
    wbData_W = '0;
    case (regFileMux_W)
      WB_ALU:  wbData_W = ALUresult_W;
      WB_MEM:  wbData_W = MEMresult_W;
      WB_PC:   wbData_W = incPC_W;
      default: wbData_W = '0;
    endcase
  end

  assign retire    = valid_W & ~noop_W;
  assign ill_write = retire & regWrtEn_W & ~is_legal_sel(regFileMux_W);
  assign commit_W  = retire & regWrtEn_W & is_legal_sel(regFileMux_W) & ~reset;

  regfile_2r1w #(
    .DBITS(DBITS),
    .REGNO(REGNO)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (commit_W),
    .wr_idx  (destIndex_W),
    .wr_data (wbData_W),
    .rd1_idx (src1Index_D),
    .rd2_idx (src2Index_D),
    .rd1_data(rf_rd1),
    .rd2_data(rf_rd2)
  );

  // Write-through so decode sees this cycle's commit without a bubble.
  assign src1Data_D = (commit_W && (src1Index_D == destIndex_W)) ? wbData_W : rf_rd1;
  assign src2Data_D = (commit_W && (src2Index_D == destIndex_W)) ? wbData_W : rf_rd2;

  always_comb begin
    retire_count_d = retire_count_q;
    wb_err_d       = wb_err_q;
    if (reset) begin
      retire_count_d = '0;
      wb_err_d       = 1'b0;
    end else begin
      if (retire) begin
        retire_count_d = retire_count_q + 32'd1;
      end
      if (ill_write) begin
        wb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    retire_count_q <= retire_count_d;
    wb_err_q       <= wb_err_d;
  end

  assign retire_count = retire_count_q;
  assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios plus random traffic checked
// against an array-based reference model of the writeback rules.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_W, noop_W, regWrtEn_W;
  logic [1:0]  regFileMux_W;
  logic [3:0]  destIndex_W, src1Index_D, src2Index_D;
  logic [31:0] ALUresult_W, MEMresult_W, incPC_W;
  logic [31:0] src1Data_D, src2Data_D, wbData_W, retire_count;
  logic        commit_W, wb_err;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .valid_W(valid_W), .noop_W(noop_W),
    .regWrtEn_W(regWrtEn_W), .regFileMux_W(regFileMux_W), .destIndex_W(destIndex_W),
    .ALUresult_W(ALUresult_W), .MEMresult_W(MEMresult_W), .incPC_W(incPC_W),
    .src1Index_D(src1Index_D), .src2Index_D(src2Index_D),
    .src1Data_D(src1Data_D), .src2Data_D(src2Data_D), .wbData_W(wbData_W),
    .commit_W(commit_W), .retire_count(retire_count), .wb_err(wb_err)
  );

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] wb;
    logic        commit;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [16];
  logic [31:0] m_cnt;
  logic        m_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endfunction

  // Applies one cycle of inputs, records the expected outputs, then advances the model.
  task automatic drive(input logic rst, input logic v, input logic nop, input logic we,
                       input logic [1:0] mux, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                       input logic [3:0] s1, input logic [3:0] s2);
    exp_t        e;
    logic [31:0] sel;
    logic        does_write;
    reset = rst; valid_W = v; noop_W = nop; regWrtEn_W = we; regFileMux_W = mux;
    destIndex_W = dest; ALUresult_W = alu; MEMresult_W = mem; incPC_W = pc;
    src1Index_D = s1; src2Index_D = s2;
    sel = (mux == 2'd0) ? alu : (mux == 2'd1) ? mem : (mux == 2'd2) ? pc : 32'd0;
    does_write = v && we && !nop && (mux != 2'd3) && !rst;
    e.wb     = sel;
    e.commit = does_write;
    e.s1     = (does_write && s1 == dest) ? sel : m_regs[s1];
    e.s2     = (does_write && s2 == dest) ? sel : m_regs[s2];
    e.cnt    = m_cnt;
    e.err    = m_err;
    exp_q.push_back(e);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      m_err = 1'b0;
    end else begin
      if (does_write) m_regs[dest] = sel;
      if (v && !nop) m_cnt = m_cnt + 32'd1;
      if (v && !nop && we && mux == 2'd3) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] s1, input logic [3:0] s2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, s1, s2);
  endtask

  // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("src1Data_D", src1Data_D, e.s1);
        chk("src2Data_D", src2Data_D, e.s2);
        chk("wbData_W", wbData_W, e.wb);
        chk("commit_W", {31'd0, commit_W}, {31'd0, e.commit});
        chk("retire_count", retire_count, e.cnt);
        chk("wb_err", {31'd0, wb_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int wait_cycles;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    m_err = 1'b0;
    reset = 1'b1; valid_W = 1'b0; noop_W = 1'b0; regWrtEn_W = 1'b0; regFileMux_W = 2'd0;
    destIndex_W = 4'd0; ALUresult_W = 32'd0; MEMresult_W = 32'd0; incPC_W = 32'd0;
    src1Index_D = 4'd0; src2Index_D = 4'd0;
    // Clear unknown state before the model is trusted, then start checking.
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) idle(4'(i), 4'(i + 8));

    // ALU write with same-cycle bypass, then held value.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd5, 32'hDEADBEEF, 32'd0, 32'd0, 4'd5, 4'd0);
    idle(4'd5, 4'd5);
    // Back-to-back MEM then PC writes to r3.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'd3, 32'd0, 32'h12345678, 32'd0, 4'd3, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'd3, 32'd0, 32'd0, 32'h40, 4'd3, 4'd5);
    idle(4'd3, 4'd3);
    // Bubble with write enable, then illegal select to r7.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'd7, 32'hFFFF, 32'd0, 32'd0, 4'd7, 4'd7);
    idle(4'd7, 4'd7);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'd7, 32'hAAAA, 32'hBBBB, 32'hCCCC, 4'd7, 4'd7);
    idle(4'd7, 4'd3);
    // Non-writing retire; write to r0; reset during a commit to r2.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd9, 32'h99, 32'd0, 32'd0, 4'd9, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 32'h0BAD0000, 32'd0, 32'd0, 4'd0, 4'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd2, 32'h22222222, 32'd0, 32'd0, 4'd2, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'd2, 32'h33333333, 32'd0, 32'd0, 4'd2, 4'd0);
    idle(4'd2, 4'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
            1'($urandom), 2'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
            4'($urandom), 4'($urandom));
    end

    // Retire counter wrap: preload near the top, then retire twice.
    force dut.retire_count_q = 32'hFFFF_FFFE;
    release dut.retire_count_q;
    m_cnt = 32'hFFFF_FFFE;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd1, 4'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd1, 4'd2);
    idle(4'd1, 4'd2);
    idle(4'd4, 4'd6);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
